multicycle_sequencer: RTL and testbench

- Multi-cycle control FSM for the RISC CPU. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB over one shared memory port.
- It generates one-cycle enable pulses for the IR, PC, register file and data memory.
- It sits beside the combinational opcode decoder, which still drives the mux selects. This block owns only the timing of the write enables and the memory handshake.
- It also counts retired instructions and detects memory time-outs.

---
 rtl/multicycle_sequencer_if.sv | 34 +++
 rtl/multicycle_sequencer.sv | 156 +++++++++++++++
 tb/tb_multicycle_sequencer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_sequencer_if.sv
// Control/handshake bundle between the multi-cycle sequencer and the datapath/memory side.
// The slave modport is the sequencer's view; the master modport drives start, opcode, zero and mem_ready.
interface multicycle_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic [3:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_we;
  logic             mem_sel;
  logic             ir_load;
  logic             pc_write;
  logic             pc_branch;
  logic             reg_write;
  logic             busy;
  logic             halted;
  logic             fault;
  logic [CNT_W-1:0] retired;
  logic [2:0]       state;

  modport master (
    output start, opcode, zero, mem_ready,
    input  mem_req, mem_we, mem_sel, ir_load, pc_write, pc_branch, reg_write,
    input  busy, halted, fault, retired, state
  );

  modport slave (
    input  start, opcode, zero, mem_ready,
    output mem_req, mem_we, mem_sel, ir_load, pc_write, pc_branch, reg_write,
    output busy, halted, fault, retired, state
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM: 3-5 cycles per instruction plus memory waits.
// Memory stalls hold the request stable until mem_ready; a stall of TIMEOUT cycles faults and halts.
module multicycle_sequencer #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_sequencer_if.slave bus
);
  localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [3:0] OP_HALT  = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h9;
  localparam logic [3:0] OP_STORE = 4'hA;
  localparam logic [3:0] OP_BNE   = 4'hB;
  localparam logic [3:0] OP_BEQ   = 4'hC;
  localparam logic [3:0] OP_MOVE  = 4'hD;
  localparam logic [3:0] OP_JUMP  = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALTED = 3'd6
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [3:0]       op_q;
  logic [CNT_W-1:0] retired_q;
  logic             fault_q;
  logic [TO_W-1:0]  to_cnt_q;

  logic mem_req;
  logic mem_sel;
  logic mem_we;
  logic ir_load;
  logic pc_write;
  logic pc_branch;
  logic reg_write;
  logic mem_wait;
  logic timeout_hit;

  // Request lines are pure state decode so they cannot glitch while waiting on mem_ready.
  assign mem_req  = (state_q == S_FETCH) || (state_q == S_MEM);
  assign mem_sel  = (state_q == S_MEM);
  assign mem_we   = mem_sel && (op_q == OP_STORE);
  assign mem_wait = mem_req && !bus.mem_ready;

  // Fires on the waiting cycle that brings the stall count up to TIMEOUT.
  assign timeout_hit = (TIMEOUT != 0) && mem_wait && (to_cnt_q == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ir_load   = 1'b0;
    pc_write  = 1'b0;
    pc_branch = 1'b0;
    reg_write = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (bus.mem_ready) begin
          ir_load = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = (bus.opcode == OP_HALT) ? S_HALTED : S_EXEC;
      end
      S_EXEC: begin
        case (op_q)
          4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, OP_MOVE: state_d = S_WB;
          OP_LOAD, OP_STORE: state_d = S_MEM;
          OP_BEQ: begin
            pc_write  = 1'b1;
            pc_branch = bus.zero;
            state_d   = S_FETCH;
          end
          OP_BNE: begin
            pc_write  = 1'b1;
            pc_branch = !bus.zero;
            state_d   = S_FETCH;
          end
          OP_JUMP: begin
            pc_write  = 1'b1;
            pc_branch = 1'b1;
            state_d   = S_FETCH;
          end
          default: begin
            pc_write = 1'b1;
            state_d  = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        if (bus.mem_ready) begin
          if (op_q == OP_STORE) begin
            pc_write = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        state_d   = S_FETCH;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
    if (timeout_hit) state_d = S_HALTED;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= 4'h0;
      retired_q <= '0;
      fault_q   <= 1'b0;
      to_cnt_q  <= '0;
    end else begin
      if (state_q == S_DECODE) op_q <= bus.opcode;
      if (pc_write) retired_q <= retired_q + CNT_W'(1);
      if (timeout_hit) fault_q <= 1'b1;
      to_cnt_q <= mem_wait ? to_cnt_q + TO_W'(1) : '0;
    end
  end

  assign bus.mem_req   = mem_req;
  assign bus.mem_sel   = mem_sel;
  assign bus.mem_we    = mem_we;
  assign bus.ir_load   = ir_load;
  assign bus.pc_write  = pc_write;
  assign bus.pc_branch = pc_branch;
  assign bus.reg_write = reg_write;
  assign bus.busy      = (state_q != S_IDLE) && (state_q != S_HALTED);
  assign bus.halted    = (state_q == S_HALTED);
  assign bus.fault     = fault_q;
  assign bus.retired   = retired_q;
  assign bus.state     = state_q;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench: a memory model feeds random programs, a monitor checks every retirement.
module tb_multicycle_sequencer;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_sequencer_if #(.CNT_W(CNT_W)) bus ();

  multicycle_sequencer #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [3:0] op;
    bit         z;
    int         fw;
    int         dw;
  } instr_t;

  typedef struct {
    int cycles;
    bit br;
    bit rw;
    bit st;
    int ret;
  } exp_t;

  instr_t prog[$];
  exp_t   expq[$];
  int     checks    = 0;
  int     errors    = 0;
  int     model_ret = 0;
  bit     stall     = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Reference: cost of an instruction from its class plus the memory waits it sees.
  task automatic issue(input logic [3:0] op, input bit z, input int fw, input int dw);
    instr_t i;
    exp_t   e;
    int     base;
    i.op = op; i.z = z; i.fw = fw; i.dw = dw;
    prog.push_back(i);
    if (op == 4'h0) return;
    e.rw = 1'b0; e.st = 1'b0; e.br = 1'b0;
    if ((op >= 4'h1 && op <= 4'h8) || op == 4'hD) begin
      base = 4; e.rw = 1'b1;
    end else if (op == 4'h9) begin
      base = 5 + dw; e.rw = 1'b1;
    end else if (op == 4'hA) begin
      base = 4 + dw; e.st = 1'b1;
    end else begin
      base = 3;
      if (op == 4'hC) e.br = z;
      else if (op == 4'hB) e.br = !z;
      else e.br = (op == 4'hF);
    end
    e.cycles  = base + fw;
    e.ret     = model_ret;
    model_ret = (model_ret + 1) % (1 << CNT_W);
    expq.push_back(e);
  endtask

  // Memory model: supplies the next instruction on each fetch and inserts the planned waits.
  bit     prev_req  = 1'b0;
  bit     prev_rdy  = 1'b0;
  int     wait_left = 0;
  instr_t cur;
  always @(posedge clk) begin
    #1;
    if (bus.mem_req) begin
      if (!prev_req || prev_rdy) begin
        if (!bus.mem_sel) begin
          if (prog.size() > 0) cur = prog.pop_front();
          else begin cur.op = 4'h0; cur.z = 1'b0; cur.fw = 0; cur.dw = 0; end
          bus.opcode = cur.op;
          bus.zero   = cur.z;
          wait_left  = cur.fw;
        end else begin
          wait_left = cur.dw;
        end
      end
      bus.mem_ready = !stall && (wait_left == 0);
      if (wait_left > 0) wait_left--;
    end else begin
      bus.mem_ready = 1'($urandom_range(0, 1));
    end
    prev_req = bus.mem_req;
    prev_rdy = bus.mem_ready;
  end

  // Monitor: every pc_write retires one instruction and is matched against the scoreboard.
  int   cyc    = 0;
  int   n_ir   = 0;
  bit   saw_rw = 1'b0;
  bit   saw_st = 1'b0;
  int   pulses;
  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      cyc = 0; n_ir = 0; saw_rw = 1'b0; saw_st = 1'b0;
    end else begin
      if (bus.busy) cyc++;
      if (bus.ir_load) n_ir++;
      if (bus.reg_write) saw_rw = 1'b1;
      if (bus.mem_we && bus.mem_ready) saw_st = 1'b1;
      pulses = int'(bus.ir_load) + int'(bus.reg_write) + int'(bus.mem_we && bus.mem_ready);
      if (pulses != 0) check("one_pulse", pulses, 1);
      if (bus.pc_write) begin
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pc_write: got pc_write=1 expected none (state %0d)", bus.state);
        end else begin
          mon_e = expq.pop_front();
          check("instr_cycles", cyc, mon_e.cycles);
          check("pc_branch", bus.pc_branch, mon_e.br);
          check("reg_write_seen", saw_rw, mon_e.rw);
          check("store_seen", saw_st, mon_e.st);
          check("ir_load_count", n_ir, 1);
          check("retired_before", bus.retired, mon_e.ret);
        end
        cyc = 0; n_ir = 0; saw_rw = 1'b0; saw_st = 1'b0;
      end
    end
  end

  function automatic logic [31:0] all_outs();
    return {bus.mem_req, bus.mem_we, bus.mem_sel, bus.ir_load, bus.pc_write, bus.pc_branch,
            bus.reg_write, bus.busy, bus.halted, bus.fault, bus.state, bus.retired};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    prog.delete();
    expq.delete();
    model_ret = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!(bus.halted && expq.size() == 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("run_completes", (n < budget), 1);
  endtask

  initial begin
    int fetch_cyc;
    int n;
    int ret_hold;
    bus.start = 1'b0; bus.opcode = 4'h0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("reset_outputs", all_outs(), 0);
    do_reset();

    // Directed prefix from the plan, then a random program ending in HALT.
    issue(4'h1, 1'b0, 0, 0);
    issue(4'h9, 1'b0, 0, 3);
    issue(4'hC, 1'b1, 0, 0);
    issue(4'hB, 1'b1, 0, 0);
    issue(4'hA, 1'b0, 0, 0);
    for (int k = 0; k < 60; k++)
      issue(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 3), $urandom_range(0, 3));
    issue(4'h0, 1'b0, $urandom_range(0, 2), 0);
    pulse_start();
    wait_done(5000);
    @(negedge clk);
    check("halt_state", bus.state, 6);
    check("halt_flag", bus.halted, 1);
    check("halt_busy", bus.busy, 0);
    check("halt_fault", bus.fault, 0);
    check("halt_retired", bus.retired, model_ret);
    ret_hold = model_ret;
    pulse_start();
    repeat (3) @(negedge clk);
    check("start_ignored_state", bus.state, 6);
    check("start_ignored_retired", bus.retired, ret_hold);
    rst_n = 1'b0;
    #1;
    check("halt_reset_state", bus.state, 0);
    check("halt_reset_outputs", all_outs(), 0);
    do_reset();

    // Memory never answers the fetch: time-out after TIMEOUT waiting cycles.
    stall = 1'b1;
    pulse_start();
    fetch_cyc = 0;
    n = 0;
    while (bus.state != 3'd6 && n < 50) begin
      @(negedge clk);
      n++;
      if (bus.state == 3'd1) fetch_cyc++;
    end
    check("timeout_fetch_cycles", fetch_cyc, TIMEOUT);
    check("timeout_state", bus.state, 6);
    check("timeout_fault", bus.fault, 1);
    check("timeout_retired", bus.retired, 0);
    stall = 1'b0;
    do_reset();
    check("fault_cleared", bus.fault, 0);

    // Asynchronous reset landing in the middle of EXEC.
    issue(4'h2, 1'b0, 0, 0);
    pulse_start();
    n = 0;
    while (bus.state != 3'd3 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("reached_exec", bus.state, 3);
    #2 rst_n = 1'b0;
    #1;
    check("midexec_reset_outputs", all_outs(), 0);
    do_reset();
    repeat (3) @(negedge clk);
    check("idle_after_reset", bus.state, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
